pwm_ramp_ctrl: RTL and testbench

//  Duty-cycle sequencer for the PWM datapath: owns the free-running PWM period counter and the duty

---
 rtl/pwm_ramp_ctrl.sv | 150 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - PWM period counter and soft-ramped duty sequencer
//
// Owns the free-running PWM period counter and the applied duty register. A new target
// duty is accepted over a valid/ready handshake while idle. The applied duty then moves
// toward the target by at most STEP per ramp step, with one step every DIV periods.
// The duty register is only written on the wrap cycle, so each new value takes effect
// from pwm_cnt == 0 and a PWM period is never cut short.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   tgt_valid    - target duty offered
//   tgt_duty     - requested duty
//   tgt_ready    - target can be accepted (IDLE only)
//   pwm_cnt      - free-running period counter
//   duty         - applied duty (PWM high while pwm_cnt < duty)
//   period_start - high while pwm_cnt == 0
//   busy         - ramp in progress
//   done         - one-cycle pulse when the applied duty reaches the accepted target
module pwm_ramp_ctrl #(
    parameter int RESOLUTION = 10,
    parameter int STEP       = 8,
    parameter int DIV        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tgt_valid,
    input  logic [RESOLUTION-1:0] tgt_duty,
    output logic                  tgt_ready,
    output logic [RESOLUTION-1:0] pwm_cnt,
    output logic [RESOLUTION-1:0] duty,
    output logic                  period_start,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LP_DIV_LAST = DW'(DIV - 1);
    localparam logic signed [RESOLUTION:0] LP_STEP = (RESOLUTION + 1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RESOLUTION-1:0]   r_pwm_cnt;
    logic [RESOLUTION-1:0]   r_duty;
    logic [RESOLUTION-1:0]   r_target;
    logic [DW-1:0]           r_div_cnt;
    logic                    w_wrap;
    logic                    w_accept;
    logic                    w_step;
    logic                    w_div_adv;
    logic signed [RESOLUTION:0] w_diff;
    logic signed [RESOLUTION:0] w_delta;
    logic [RESOLUTION-1:0]   w_duty_stepped;

    assign w_wrap       = &r_pwm_cnt;
    assign period_start = (r_pwm_cnt == '0);
    assign pwm_cnt      = r_pwm_cnt;
    assign duty         = r_duty;

    // Signed distance to target, one bit wider than duty so both directions fit.
    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});

    // Clamp the step to the remaining distance: the ramp lands exactly on the target
    // and the sum below can never leave 0..2**RESOLUTION-1.
    always_comb begin
        w_delta = '0;
        if (w_diff > 0) begin
            w_delta = (w_diff > LP_STEP) ? LP_STEP : w_diff;
        end else if (w_diff < 0) begin
            w_delta = (-w_diff > LP_STEP) ? -LP_STEP : w_diff;
        end
    end

    assign w_duty_stepped = r_duty + w_delta[RESOLUTION-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_div_adv   = 1'b0;
        tgt_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (tgt_duty == r_duty) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                busy = 1'b1;
                if (w_wrap) begin
                    if (r_div_cnt == LP_DIV_LAST) begin
                        w_step = 1'b1;
                        if (w_duty_stepped == r_target) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_div_adv = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_target  <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_accept) begin
                r_target  <= tgt_duty;
                r_div_cnt <= '0;
            end
            if (w_step) begin
                r_duty    <= w_duty_stepped;
                r_div_cnt <= '0;
            end else if (w_div_adv) begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard testbench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    typedef struct {
        bit is_done;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid1 = 1'b0;
    logic [3:0] tdut1 = '0;
    logic       ready1, pstart1, busy1, done1;
    logic [3:0] cnt1, duty1;
    logic       valid2 = 1'b0;
    logic [3:0] tdut2 = '0;
    logic       ready2, pstart2, busy2, done2;
    logic [3:0] cnt2, duty2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    logic [3:0] prev1, prev2;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.RESOLUTION(4), .STEP(3), .DIV(1)) u_dut (
        .clk(clk), .rst(rst), .tgt_valid(valid1), .tgt_duty(tdut1), .tgt_ready(ready1),
        .pwm_cnt(cnt1), .duty(duty1), .period_start(pstart1), .busy(busy1), .done(done1)
    );

    pwm_ramp_ctrl #(.RESOLUTION(4), .STEP(15), .DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .tgt_valid(valid2), .tgt_duty(tdut2), .tgt_ready(ready2),
        .pwm_cnt(cnt2), .duty(duty2), .period_start(pstart2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit is_done, input int val);
        exp_t e;
        e.is_done = is_done;
        e.val     = val;
        return e;
    endfunction

    // Monitors: any change of duty or any done pulse is a DUT event and must match the
    // next expected entry. Duty may only change where pwm_cnt has just wrapped to 0.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev1 = duty1;
        end else begin
            if (duty1 !== prev1) begin
                chk("dut1_duty_change_at_period_start", int'(cnt1), 0);
                if (sb1.size() == 0) begin
                    chk("dut1_unexpected_duty_change", int'(duty1), int'(prev1));
                end else begin
                    e = sb1.pop_front();
                    chk("dut1_event_kind_duty", int'(e.is_done), 0);
                    chk("dut1_duty_value", int'(duty1), e.val);
                end
                prev1 = duty1;
            end
            if (done1) begin
                if (sb1.size() == 0) begin
                    chk("dut1_unexpected_done", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    chk("dut1_event_kind_done", int'(e.is_done), 1);
                    chk("dut1_done_duty", int'(duty1), e.val);
                    chk("dut1_done_not_busy", int'(busy1), 0);
                    chk("dut1_done_not_ready", int'(ready1), 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev2 = duty2;
        end else begin
            if (duty2 !== prev2) begin
                chk("dut2_duty_change_at_period_start", int'(cnt2), 0);
                if (sb2.size() == 0) begin
                    chk("dut2_unexpected_duty_change", int'(duty2), int'(prev2));
                end else begin
                    e = sb2.pop_front();
                    chk("dut2_event_kind_duty", int'(e.is_done), 0);
                    chk("dut2_duty_value", int'(duty2), e.val);
                end
                prev2 = duty2;
            end
            if (done2) begin
                if (sb2.size() == 0) begin
                    chk("dut2_unexpected_done", 1, 0);
                end else begin
                    e = sb2.pop_front();
                    chk("dut2_event_kind_done", int'(e.is_done), 1);
                    chk("dut2_done_duty", int'(duty2), e.val);
                end
            end
        end
    end

    // Offer a target to DUT1 once it is ready (optionally only on a wrap cycle).
    task automatic send1(input int d, input bit on_wrap);
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ready1 && (!on_wrap || cnt1 == 4'hF)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send1_ready_timeout", 0, 1);
        valid1 = 1'b1;
        tdut1  = 4'(d);
        @(posedge clk);
        #1 valid1 = 1'b0;
    endtask

    task automatic wait_ready1();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready1) begin
                ok = 1;
                break;
            end
        end
        chk("wait_ready1_timeout", int'(ok), 1);
    endtask

    task automatic wait_duty1(input int d);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (duty1 == 4'(d)) begin
                ok = 1;
                break;
            end
        end
        chk("wait_duty1_timeout", int'(ok), 1);
    endtask

    task automatic wait_cnt2_zero();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt2 == 4'h0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_cnt2_zero_timeout", int'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: asynchronous reset mid-cycle, then one full counter period
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("reset_pwm_cnt", int'(cnt1), 0);
        chk("reset_duty", int'(duty1), 0);
        chk("reset_tgt_ready", int'(ready1), 1);
        chk("reset_period_start", int'(pstart1), 1);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_done", int'(done1), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            chk("count_pwm_cnt", int'(cnt1), i % 16);
            chk("count_period_start", int'(pstart1), (i % 16 == 0) ? 1 : 0);
        end

        // 2: ramp 0 -> 10, accepted on a wrap cycle (that wrap is not a step)
        sb1.push_back(mk(0, 3));
        sb1.push_back(mk(0, 6));
        sb1.push_back(mk(0, 9));
        sb1.push_back(mk(0, 10));
        sb1.push_back(mk(1, 10));
        send1(10, 1);
        @(negedge clk);
        chk("accept_on_wrap_no_step", int'(duty1), 0);
        chk("ramp_up_busy", int'(busy1), 1);
        chk("ramp_up_not_ready", int'(ready1), 0);
        wait_ready1();
        chk("ramp_up_final", int'(duty1), 10);

        // 3: ramp 10 -> 0, clamped at zero
        sb1.push_back(mk(0, 7));
        sb1.push_back(mk(0, 4));
        sb1.push_back(mk(0, 1));
        sb1.push_back(mk(0, 0));
        sb1.push_back(mk(1, 0));
        send1(0, 0);
        wait_ready1();
        chk("ramp_down_final", int'(duty1), 0);

        // 4: back to 10, then equal target
        sb1.push_back(mk(0, 3));
        sb1.push_back(mk(0, 6));
        sb1.push_back(mk(0, 9));
        sb1.push_back(mk(0, 10));
        sb1.push_back(mk(1, 10));
        send1(10, 0);
        wait_ready1();
        sb1.push_back(mk(1, 10));
        send1(10, 0);
        @(negedge clk);
        chk("equal_done_pulse", int'(done1), 1);
        chk("equal_duty_kept", int'(duty1), 10);
        @(negedge clk);
        chk("equal_done_one_cycle", int'(done1), 0);
        chk("equal_back_to_idle", int'(ready1), 1);

        // 5: tgt_valid held during a ramp is ignored; then reset mid-ramp
        sb1.push_back(mk(0, 13));
        sb1.push_back(mk(0, 15));
        sb1.push_back(mk(1, 15));
        send1(15, 0);
        valid1 = 1'b1;
        tdut1  = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ignore_valid_busy", int'(busy1), 1);
        end
        valid1 = 1'b0;
        wait_ready1();
        chk("ignore_valid_final", int'(duty1), 15);

        sb1.push_back(mk(0, 12));
        sb1.push_back(mk(0, 9));
        send1(0, 0);
        valid1 = 1'b1;
        tdut1  = 4'd2;
        repeat (8) @(negedge clk);
        valid1 = 1'b0;
        wait_duty1(9);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midramp_reset_duty", int'(duty1), 0);
        chk("midramp_reset_ready", int'(ready1), 1);
        chk("midramp_reset_busy", int'(busy1), 0);
        chk("midramp_reset_done", int'(done1), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk("midramp_reset_queue_drained", sb1.size(), 0);
        repeat (40) @(negedge clk);
        chk("after_reset_duty_stays", int'(duty1), 0);

        // 6: DIV=2, STEP=15 -> single jump to 15 on the second wrap after accept
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt2 == 4'd5) break;
        end
        sb2.push_back(mk(0, 15));
        sb2.push_back(mk(1, 15));
        valid2 = 1'b1;
        tdut2  = 4'd15;
        @(posedge clk);
        #1 valid2 = 1'b0;
        chk("div2_busy", int'(busy2), 1);
        wait_cnt2_zero();
        chk("div2_first_wrap_no_step", int'(duty2), 0);
        wait_cnt2_zero();
        chk("div2_second_wrap_step", int'(duty2), 15);
        chk("div2_done", int'(done2), 1);
        @(negedge clk);
        chk("div2_idle", int'(ready2), 1);

        repeat (4) @(negedge clk);
        chk("sb1_empty", sb1.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
